serial_add_scheduler: RTL and testbench

- Shares one external `serial_adder_with_vld` instance between two parallel-operand requesters.
- Arbitrates round-robin between the requesters and shifts the granted operands into the adder LSB-first, one bit per cycle, framed with vld/last.
- Collects the serial sum bits and returns a W-bit parallel result through a valid/ready response port.

---
 rtl/serial_add_scheduler.sv | 120 ++++++++++++
 tb/tb_serial_add_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_scheduler.sv
// Purpose : shares one external bit-serial adder between two parallel-operand
//           requesters (round-robin), serialises LSB-first, returns a W-bit sum.
// Latency : rsp_vld rises W edges after the accept edge; one op per W+2 cycles.
// Backpr. : result held in DONE until rsp_rdy; no request accepted outside IDLE.
//
// Ports:
//   clk, rst                      clock, async active-low reset
//   req{0,1}_vld/_rdy/_a/_b       requester operand ports (valid/ready)
//   sa_vld, sa_a, sa_b, sa_last   bit stream to the serial adder
//   sa_sum                        combinational sum bit from the serial adder
//   rsp_vld, rsp_rdy, rsp_sum, rsp_id   parallel result port (valid/ready)
module serial_add_scheduler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_vld,
  output logic         req0_rdy,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_vld,
  output logic         req1_rdy,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         sa_vld,
  output logic         sa_a,
  output logic         sa_b,
  output logic         sa_last,
  input  logic         sa_sum,
  output logic         rsp_vld,
  input  logic         rsp_rdy,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_id
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic          rr;        // requester preferred when both are valid
  logic [CW-1:0] cnt;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [W-1:0]  res;
  logic          id;

  logic          gnt1;
  logic          any_req;
  logic          in_idle;
  logic          in_run;
  logic [W-1:0]  res_next;

  always_comb begin
    gnt1    = req1_vld && (!req0_vld || rr);
    any_req = req0_vld || req1_vld;
    in_idle = (state == IDLE);
    in_run  = (state == RUN);
    // Sum bits arrive LSB-first; each new bit enters at the MSB so that after
    // W shifts the first bit received sits in bit 0.
    res_next        = res >> 1;
    res_next[W-1]   = sa_sum;
  end

  // rst gating keeps the ready outputs low while reset is held even if a
  // requester is already presenting valid.
  assign req0_rdy = rst && in_idle && req0_vld && !gnt1;
  assign req1_rdy = rst && in_idle && gnt1;

  assign sa_vld  = in_run;
  assign sa_a    = in_run && op_a[0];
  assign sa_b    = in_run && op_b[0];
  assign sa_last = in_run && (cnt == LAST_BIT);

  assign rsp_vld = (state == DONE);
  assign rsp_sum = rsp_vld ? res : '0;
  assign rsp_id  = rsp_vld && id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr    <= 1'b0;
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_a  <= gnt1 ? req1_a : req0_a;
            op_b  <= gnt1 ? req1_b : req0_b;
            id    <= gnt1;
            rr    <= !gnt1;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          op_a <= op_a >> 1;
          op_b <= op_b >> 1;
          res  <= res_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (rsp_rdy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_scheduler.sv
module tb_serial_add_scheduler;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_vld, req1_vld;
  logic         req0_rdy, req1_rdy;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         sa_vld, sa_a, sa_b, sa_last, sa_sum;
  logic         rsp_vld, rsp_rdy, rsp_id;
  logic [W-1:0] rsp_sum;

  int n_cmp  = 0;
  int n_fail = 0;
  logic last_gnt;   // model: requester granted most recently (1 after reset)

  always #5 clk = ~clk;

  serial_add_scheduler #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_a(req0_a), .req0_b(req0_b),
    .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_a(req1_a), .req1_b(req1_b),
    .sa_vld(sa_vld), .sa_a(sa_a), .sa_b(sa_b), .sa_last(sa_last), .sa_sum(sa_sum),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_sum(rsp_sum), .rsp_id(rsp_id)
  );

  // Behavioural serial adder: sum combinational in a, b and carry register.
  logic carry;
  assign sa_sum = sa_a ^ sa_b ^ carry;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) carry <= 1'b0;
    else if (sa_vld) carry <= sa_last ? 1'b0 : ((sa_a & sa_b) | (carry & (sa_a ^ sa_b)));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Handshake protocol invariants, checked every cycle.
  always @(negedge clk) begin
    n_cmp++;
    if ((req0_rdy && !req0_vld) || (req1_rdy && !req1_vld) || (req0_rdy && req1_rdy)) begin
      n_fail++;
      $display("FAIL rdy_protocol: vld=%b%b rdy=%b%b at %0t",
               req1_vld, req0_vld, req1_rdy, req0_rdy, $time);
    end
  end

  // One operation, from the current IDLE state back to IDLE. The expected
  // grant comes from the round-robin rule; the sum is either the supplied
  // constant or a+b mod 2^W of the operands offered at accept time.
  task automatic op(input logic [W-1:0] sum_const, input logic use_model,
                    input logic hold, input int bp, output logic gid);
    logic eid;
    logic [W-1:0] a, b, es;
    int k;
    gid = 1'b0;
    #1;
    k = 0;
    while (!(req0_rdy || req1_rdy) && k < 20) begin
      step();
      k++;
    end
    if (k == 20) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got no rdy, want rdy within 20 cycles");
      return;
    end
    eid = (req0_vld && req1_vld) ? ~last_gnt : req1_vld;
    gid = req1_rdy;
    chk("grant", {30'd0, req1_rdy, req0_rdy}, eid ? 32'd2 : 32'd1);
    a  = eid ? req1_a : req0_a;
    b  = eid ? req1_b : req0_b;
    es = use_model ? W'(a + b) : sum_const;
    last_gnt = eid;
    rsp_rdy = (bp == 0);
    step();
    // Requester side changes during RUN must not matter.
    if (eid) begin
      req1_a = W'($urandom); req1_b = W'($urandom);
      if (!hold) req1_vld = 1'b0;
    end else begin
      req0_a = W'($urandom); req0_b = W'($urandom);
      if (!hold) req0_vld = 1'b0;
    end
    #1;
    for (int i = 0; i < W; i++) begin
      chk("sa_bus", {28'd0, sa_vld, sa_last, sa_a, sa_b},
          {28'd0, 1'b1, (i == W-1), a[i], b[i]});
      chk("run_quiet", {29'd0, req0_rdy, req1_rdy, rsp_vld}, 32'd0);
      step();
      #1;
    end
    chk("rsp", {23'd0, rsp_vld, rsp_id, rsp_sum}, {23'd0, 1'b1, eid, es});
    chk("done_quiet", {29'd0, req0_rdy, req1_rdy, sa_vld}, 32'd0);
    if (bp > 0) begin
      for (int j = 1; j < bp; j++) begin
        step();
        chk("rsp_hold", {23'd0, rsp_vld, rsp_id, rsp_sum}, {23'd0, 1'b1, eid, es});
        chk("hold_quiet", {29'd0, req0_rdy, req1_rdy, sa_vld}, 32'd0);
      end
      step();
      rsp_rdy = 1'b1;
      #1;
      chk("rsp_hs", {23'd0, rsp_vld, rsp_id, rsp_sum}, {23'd0, 1'b1, eid, es});
    end
    step();
    chk("rsp_drop", {31'd0, rsp_vld}, 32'd0);
  endtask

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
  } vec_t;

  vec_t vecs[7];
  logic g;
  logic v0, v1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 8'h35, 8'h4A, 8'h7F};
    vecs[1] = '{1'b1, 8'hFF, 8'h01, 8'h00};
    vecs[2] = '{1'b1, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{1'b0, 8'h80, 8'h80, 8'h00};
    vecs[4] = '{1'b1, 8'hAA, 8'h55, 8'hFF};
    vecs[5] = '{1'b0, 8'hFF, 8'hFF, 8'hFE};
    vecs[6] = '{1'b0, 8'h01, 8'h7F, 8'h80};

    rst = 1'b0; rsp_rdy = 1'b0;
    req0_vld = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
    req1_vld = 1'b0; req1_a = '0; req1_b = '0;
    last_gnt = 1'b1;
    step(); step();
    chk("reset_outs", {16'd0, req0_rdy, req1_rdy, sa_vld, sa_a, sa_b, sa_last,
                       rsp_vld, rsp_id, rsp_sum}, 32'd0);
    req0_vld = 1'b0;
    step();
    rst = 1'b1;
    step();

    // Table-driven single-requester operations.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].id) begin
        req1_vld = 1'b1; req1_a = vecs[i].a; req1_b = vecs[i].b;
      end else begin
        req0_vld = 1'b1; req0_a = vecs[i].a; req0_b = vecs[i].b;
      end
      op(vecs[i].sum, 1'b0, 1'b0, 0, g);
    end

    // Contention: both held from reset release.
    rst = 1'b0;
    req0_vld = 1'b1; req0_a = 8'h10; req0_b = 8'h20;
    req1_vld = 1'b1; req1_a = 8'h7F; req1_b = 8'h01;
    step();
    rst = 1'b1; last_gnt = 1'b1;
    op(8'h30, 1'b0, 1'b0, 0, g);
    chk("cont_first_id", {31'd0, g}, 32'd0);
    op(8'h80, 1'b0, 1'b0, 0, g);
    chk("cont_second_id", {31'd0, g}, 32'd1);

    // Backpressure: 5 cycles of rsp_rdy=0 in DONE.
    req0_vld = 1'b1; req0_a = 8'h21; req0_b = 8'h43;
    op(8'h64, 1'b0, 1'b0, 5, g);

    // Reset in the middle of RUN.
    req0_vld = 1'b1; req0_a = 8'hAA; req0_b = 8'h55;
    #1;
    step();
    req0_vld = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    #1;
    chk("midrun_reset_outs", {16'd0, req0_rdy, req1_rdy, sa_vld, sa_a, sa_b, sa_last,
                              rsp_vld, rsp_id, rsp_sum}, 32'd0);
    step();
    rst = 1'b1; last_gnt = 1'b1; rsp_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_stale_rsp", {30'd0, sa_vld, rsp_vld}, 32'd0);
    end
    req0_vld = 1'b1; req0_a = 8'h0F; req0_b = 8'h01;
    op(8'h10, 1'b0, 1'b0, 0, g);

    // Fairness: both valid held for 6 ops, fresh random operands each time.
    rst = 1'b0;
    req0_vld = 1'b1; req0_a = W'($urandom); req0_b = W'($urandom);
    req1_vld = 1'b1; req1_a = W'($urandom); req1_b = W'($urandom);
    step();
    rst = 1'b1; last_gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op('0, 1'b1, 1'b1, 0, g);
      chk("fair_id", {31'd0, g}, (i % 2));
    end
    req0_vld = 1'b0; req1_vld = 1'b0;

    // Randomised traffic against the round-robin / a+b model.
    for (int i = 0; i < 20; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v0) begin req0_vld = 1'b1; req0_a = W'($urandom); req0_b = W'($urandom); end
      if (v1) begin req1_vld = 1'b1; req1_a = W'($urandom); req1_b = W'($urandom); end
      op('0, 1'b1, 1'b0, $urandom_range(0, 3), g);
    end
    req0_vld = 1'b0; req1_vld = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
